// File: rtl/root_unit_pkg.sv
// Shared definitions for the iterative integer root engine: mode codes,
// controller states and the per-mode digit count.
package root_unit_pkg;

    localparam logic MODE_SQRT = 1'b0;
    localparam logic MODE_CBRT = 1'b1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // One result bit is produced per iteration, so the count is the result width.
    function automatic int iters(input int width, input logic mode);
        if (mode == MODE_CBRT) begin
            return (width + 2) / 3;
        end
        return (width + 1) / 2;
    endfunction

endpackage

// File: rtl/root_unit_step.sv
// One digit of the restoring root recurrence: doubles the partial root and
// subtracts the shifted increment (y+1)^k - y^k when the remainder allows it.
module root_unit_step
    import root_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [(WIDTH+1)/2-1:0] y,
    input  logic [WIDTH-1:0]       rem,
    input  logic [5:0]             shift,
    input  logic                   mode,
    output logic [(WIDTH+1)/2-1:0] y_next,
    output logic [WIDTH-1:0]       rem_next
);

    localparam int RW = (WIDTH + 1) / 2;
    localparam int BW = WIDTH + 3;

    logic [BW-1:0] yd;
    logic [BW-1:0] b_sq;
    logic [BW-1:0] b_cb;
    logic [BW-1:0] b;
    logic [BW-1:0] rem_ext;
    logic          take;

    // Three guard bits keep the increment exact even when it exceeds the remainder.
    assign yd      = {{(BW-RW-1){1'b0}}, y, 1'b0};
    assign rem_ext = {3'b000, rem};
    assign b_sq    = ((yd << 1) | BW'(1)) << shift;
    assign b_cb    = ((BW'(3) * yd * (yd + BW'(1))) + BW'(1)) << shift;
    assign b       = (mode == MODE_CBRT) ? b_cb : b_sq;
    assign take    = (rem_ext >= b);

    assign rem_next = take ? (rem - b[WIDTH-1:0]) : rem;
    assign y_next   = take ? (yd[RW-1:0] | RW'(1)) : yd[RW-1:0];

endmodule

// File: rtl/root_unit.sv
// Iterative floor square/cube root with remainder; start/busy handshake and
// a one-cycle done pulse when the result registers update.
module root_unit
    import root_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       x_i,
    input  logic                   mode_i,
    input  logic                   start,
    output logic [(WIDTH+1)/2-1:0] result,
    output logic [WIDTH-1:0]       rem_o,
    output logic                   busy,
    output logic                   done
);

    localparam int RW = (WIDTH + 1) / 2;
    localparam int CW = 6;

    state_t         state_reg;
    logic           mode_reg;
    logic [CW-1:0]  cnt_reg;
    logic [RW-1:0]  y_reg;
    logic [WIDTH-1:0] rem_reg;

    logic [CW-1:0]  cnt_m1;
    logic [5:0]     shift;
    logic [RW-1:0]  y_next;
    logic [WIDTH-1:0] rem_next;

    assign cnt_m1 = cnt_reg - CW'(1);
    assign shift  = (mode_reg == MODE_CBRT) ? 6'(cnt_m1 * CW'(3)) : 6'(cnt_m1 << 1);

    root_unit_step #(.WIDTH(WIDTH)) u_step (
        .y        (y_reg),
        .rem      (rem_reg),
        .shift    (shift),
        .mode     (mode_reg),
        .y_next   (y_next),
        .rem_next (rem_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            mode_reg  <= MODE_SQRT;
            cnt_reg   <= '0;
            y_reg     <= '0;
            rem_reg   <= '0;
            result    <= '0;
            rem_o     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rem_reg   <= x_i;
                        mode_reg  <= mode_i;
                        y_reg     <= '0;
                        cnt_reg   <= CW'(iters(WIDTH, mode_i));
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    y_reg   <= y_next;
                    rem_reg <= rem_next;
                    cnt_reg <= cnt_m1;
                    // The last digit lands straight in the output registers.
                    if (cnt_reg == CW'(1)) begin
                        result    <= y_next;
                        rem_o     <= rem_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_root_unit.sv
// Randomised and directed bench for root_unit at WIDTH=8 and WIDTH=16 against
// a brute-force root model with a cycle-count view of the handshake.
module tb_root_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [7:0]  x8 = '0;
    logic        m8 = 1'b0;
    logic        st8 = 1'b0;
    logic [3:0]  result8;
    logic [7:0]  rem8;
    logic        busy8, done8;

    logic [15:0] x16 = '0;
    logic        m16 = 1'b0;
    logic        st16 = 1'b0;
    logic [7:0]  result16;
    logic [15:0] rem16;
    logic        busy16, done16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    root_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .x_i(x8), .mode_i(m8), .start(st8),
        .result(result8), .rem_o(rem8), .busy(busy8), .done(done8)
    );

    root_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .x_i(x16), .mode_i(m16), .start(st16),
        .result(result16), .rem_o(rem16), .busy(busy16), .done(done16)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint pw(input longint r, input bit cube);
        return cube ? r * r * r : r * r;
    endfunction

    function automatic longint froot(input longint x, input bit cube);
        longint r = 0;
        while (pw(r + 1, cube) <= x) r++;
        return r;
    endfunction

    function automatic int niters(input int w, input bit cube);
        return cube ? (w + 2) / 3 : (w + 1) / 2;
    endfunction

    // Model: an accepted op keeps busy for N edges, then publishes its root.
    int     ml8 = 0, ml16 = 0;
    bit     md8 = 0, md16 = 0;
    longint mr8 = 0, mm8 = 0, pr8 = 0, pm8 = 0;
    longint mr16 = 0, mm16 = 0, pr16 = 0, pm16 = 0;

    always @(posedge clk) begin
        if (!rst) begin
            ml8 = 0; md8 = 0; mr8 = 0; mm8 = 0;
        end else if (ml8 > 0) begin
            ml8--;
            md8 = (ml8 == 0);
            if (ml8 == 0) begin mr8 = pr8; mm8 = pm8; end
        end else begin
            md8 = 0;
            if (st8) begin
                ml8 = niters(8, m8);
                pr8 = froot(x8, m8);
                pm8 = x8 - pw(pr8, m8);
            end
        end
        #1;
        chk("busy8", busy8, ml8 > 0);
        chk("done8", done8, md8);
        chk("result8", result8, mr8);
        chk("rem8", rem8, mm8);
    end

    always @(posedge clk) begin
        if (!rst) begin
            ml16 = 0; md16 = 0; mr16 = 0; mm16 = 0;
        end else if (ml16 > 0) begin
            ml16--;
            md16 = (ml16 == 0);
            if (ml16 == 0) begin mr16 = pr16; mm16 = pm16; end
        end else begin
            md16 = 0;
            if (st16) begin
                ml16 = niters(16, m16);
                pr16 = froot(x16, m16);
                pm16 = x16 - pw(pr16, m16);
            end
        end
        #1;
        chk("busy16", busy16, ml16 > 0);
        chk("done16", done16, md16);
        chk("result16", result16, mr16);
        chk("rem16", rem16, mm16);
    end

    task automatic op8(input int x, input bit cube, input int er, input int em, input int en);
        int n = 0;
        @(negedge clk);
        x8 = 8'(x); m8 = cube; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        while (busy8 && n < 100) begin n++; @(negedge clk); end
        chk("op8_busy_cycles", n, en);
        chk("op8_done", done8, 1);
        chk("op8_result", result8, er);
        chk("op8_rem", rem8, em);
        $display("op8 mode=%0d x=%0d result=%0d rem=%0d cycles=%0d", cube, x, result8, rem8, n);
    endtask

    task automatic op16(input int x, input bit cube, input int er, input int em, input int en);
        int n = 0;
        @(negedge clk);
        x16 = 16'(x); m16 = cube; st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        while (busy16 && n < 100) begin n++; @(negedge clk); end
        chk("op16_busy_cycles", n, en);
        chk("op16_result", result16, er);
        chk("op16_rem", rem16, em);
        $display("op16 mode=%0d x=%0d result=%0d rem=%0d cycles=%0d", cube, x, result16, rem16, n);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_result", result8, 0);
        chk("reset_busy", busy8, 0);
        rst = 1'b1;

        // Directed cases with hand-computed results.
        op8(27, 1, 3, 0, 3);
        op8(8, 1, 2, 0, 3);
        op8(64, 1, 4, 0, 3);
        op8(125, 1, 5, 0, 3);
        op8(216, 1, 6, 0, 3);
        op8(255, 1, 6, 39, 3);
        op8(200, 0, 14, 4, 4);
        op8(0, 0, 0, 0, 4);
        op8(255, 0, 15, 30, 4);

        // A second start one cycle into the operation must be ignored.
        @(negedge clk);
        x8 = 8'd125; m8 = 1'b1; st8 = 1'b1;
        @(negedge clk);
        x8 = 8'd64; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("ignore_result", result8, 5);
        chk("ignore_rem", rem8, 0);
        $display("ignored-start x=125 result=%0d rem=%0d", result8, rem8);

        // Asynchronous abort mid-operation.
        @(negedge clk);
        x8 = 8'd216; m8 = 1'b1; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_result", result8, 0);
        chk("abort_rem", rem8, 0);
        $display("abort busy=%0d result=%0d rem=%0d", busy8, result8, rem8);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        op8(27, 1, 3, 0, 3);

        op16(65535, 1, 40, 1535, 6);
        op16(65535, 0, 255, 510, 8);

        // Exhaustive sweep at WIDTH=8, expectations from the brute-force root.
        for (int k = 0; k < 2; k++) begin
            for (int x = 0; x < 256; x++) begin
                longint r;
                r = froot(x, k[0]);
                op8(x, k[0], int'(r), int'(x - pw(r, k[0])), niters(8, k[0]));
                chk("sweep_bracket",
                    (pw(result8, k[0]) <= x) && (pw(longint'(result8) + 1, k[0]) > x), 1);
            end
        end

        // Random traffic, including starts while busy and held starts.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            st8  = ($urandom_range(0, 3) != 0);
            x8   = 8'($urandom);
            m8   = 1'($urandom);
            st16 = ($urandom_range(0, 3) != 0);
            x16  = 16'($urandom);
            m16  = 1'($urandom);
        end
        @(negedge clk);
        st8 = 1'b0; st16 = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
